nreg_sipo_deser: RTL and testbench
==================================

// Module: nreg_sipo_deser
// PURPOSE
//  Serial-in/parallel-out deserializer. Sits directly upstream of the N-bit register
//    stage and produces the parallel word that drives its io_D input.
//  Collects qualified serial bits into WIDTH-bit words and holds each finished word
//    in a one-entry output buffer with a valid/ready handshake.
//  Detects overrun: a word completes while the buffer is still full.
// PARAMETERS
//  WIDTH      8   bits per word; legal range 2..32
//  MSB_FIRST  0   0: first received bit lands in bit 0; 1: first bit lands in bit WIDTH-1
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      asynchronous active-low reset
//  io_bit_in     in   1      serial data bit
//  io_bit_valid  in   1      io_bit_in is accepted on this edge
//  io_sync       in   1      frame sync: discards the partial word
//  io_D_out      out  WIDTH  assembled word (feeds register io_D)
//  io_valid      out  1      io_D_out holds an unconsumed word
//  io_ready      in   1      consumer takes the word when io_valid & io_ready
//  io_overrun    out  1      sticky overrun flag
//  io_bitcnt     out  clog2(WIDTH)  number of bits in the partial word
// BEHAVIOUR
//  Reset (asynchronous; release is synchronous to clk) clears all of the following to 0:
//    shift register, io_bitcnt, io_D_out, io_valid, io_overrun; output FSM = EMPTY.
//    Reset asserted mid-word discards the partial word and any buffered word.
//  Shift
//    - Each edge with io_bit_valid=1 and io_sync=0 shifts in one bit and does cnt+1.
//    - MSB_FIRST=0: shreg = {bit, shreg[W-1:1]}.  MSB_FIRST=1: shreg = {shreg[W-2:0], bit}.
//  Completion
//    - The WIDTH-th accepted bit (cnt==WIDTH-1) completes the word; cnt wraps to 0.
//    - The word, including the bit accepted on that edge, becomes the buffer candidate.
//  io_sync
//    - io_sync=1 forces cnt=0 and ignores io_bit_valid on that edge.
//    - A buffered word is not affected.
//  Output FSM, states EMPTY and FULL (io_valid = FULL):
//    - EMPTY -> FULL on completion. io_D_out loads the word.
//      Latency: io_valid rises 1 cycle after the completing bit edge.
//    - FULL & io_ready & !completion -> EMPTY. io_D_out keeps its last value.
//    - FULL & io_ready & completion -> stay FULL. Back-to-back load with no bubble.
//    - FULL & !io_ready & completion -> stay FULL. The new word is dropped and
//      io_overrun is set to 1. The buffered word is preserved.
//    - FULL & !io_ready & !completion -> hold. io_D_out stays stable while io_valid=1.
//  Flags and handshake
//    - io_overrun stays set until reset_n.
//    - io_ready is ignored while the FSM is EMPTY.
//    - No combinational path from io_ready to io_valid or io_D_out.
//  Width: the counter is sized clog2(WIDTH) and never exceeds WIDTH-1.
// CONFIGURATION
//  NREG_DESER_PARITY_EN defined:
//    - Each frame is WIDTH data bits followed by one even-parity bit.
//    - Completion happens on the parity bit; cnt runs 0..WIDTH.
//    - Adds output port io_parity_err (1 bit, reset 0). It is loaded along with
//      io_D_out: 1 when XOR(data bits, parity bit) != 0.
//    - The word is delivered in both cases.
//    - Overrun and io_sync rules apply to the whole frame.
//  NREG_DESER_PARITY_EN undefined:
//    - No parity bit and no io_parity_err port; behaviour exactly as above.
// TESTING
//  1. W=8, MSB_FIRST=0, io_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles
//     -> io_D_out=8'hA5; io_valid high for 1 cycle, 1 cycle after the 8th bit.
//  2. MSB_FIRST=1, same bit stream -> io_D_out=8'hA5 (first bit in bit 7).
//  3. io_ready=0: send 8'h3C, then 8'hFF
//     -> io_D_out stays 8'h3C, io_valid=1, io_overrun=1.
//     Then io_ready=1 -> 8'h3C is consumed, io_valid falls.
//  4. Continuous stream 8'h11, 8'h22 with io_ready pulsed exactly on the completion
//     edge of 8'h22 -> io_valid stays 1 and io_D_out goes 8'h11 -> 8'h22; no overrun.
//  5. 5 bits sent, io_sync=1, then 8 bits of 8'h0F
//     -> io_D_out=8'h0F and io_bitcnt=0 after sync. Reset_n pulsed at bit 4
//     -> all outputs 0 immediately.
//  6. PARITY_EN: 8'h07 + parity 1 -> io_parity_err=0; 8'h07 + parity 0 -> io_parity_err=1.

Source files
------------

// File: rtl/nreg_sipo_deser.sv
// nreg_sipo_deser: serial-in/parallel-out deserializer feeding the N-bit register io_D input.
// Bits are collected into WIDTH-bit words and each finished word sits in a one-entry
// valid/ready buffer; a word that completes while the buffer is full sets a sticky overrun.
// Optional feature macro NREG_DESER_PARITY_EN: each frame carries one trailing even-parity
// bit, completion moves to that bit and an io_parity_err flag is delivered with the word.
module nreg_sipo_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0,
`ifdef NREG_DESER_PARITY_EN
   localparam int FRAME    = WIDTH + 1,
`else
   localparam int FRAME    = WIDTH,
`endif
   localparam int CW       = $clog2(FRAME)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             io_bit_in,
   input  logic             io_bit_valid,
   input  logic             io_sync,
   output logic [WIDTH-1:0] io_D_out,
   output logic             io_valid,
   input  logic             io_ready,
   output logic             io_overrun,
`ifdef NREG_DESER_PARITY_EN
   output logic [CW-1:0]    io_bitcnt,
   output logic             io_parity_err
`else
   output logic [CW-1:0]    io_bitcnt
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] shift_nxt, word;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovr_q, ovr_d;
   logic             accept, complete, data_bit;
`ifdef NREG_DESER_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
   logic             word_perr;
`endif

   // a sync edge never accepts a bit; the last bit of a frame is the completing one
   assign accept    = io_bit_valid & ~io_sync;
   assign complete  = accept & (cnt_q == LAST);
   assign shift_nxt = MSB_FIRST ? {shreg_q[WIDTH-2:0], io_bit_in}
                                : {io_bit_in, shreg_q[WIDTH-1:1]};

`ifdef NREG_DESER_PARITY_EN
   // the parity bit is not shifted: the data word is already whole when it arrives
   assign data_bit  = accept & (cnt_q != LAST);
   assign word      = shreg_q;
   assign word_perr = par_q ^ io_bit_in;
`else
   // the completing bit is part of the word, so the candidate is the shifted value
   assign data_bit  = accept;
   assign word      = shift_nxt;
`endif

   // shift register and bit counter next state; sync or completion restarts the frame
   always_comb begin
      shreg_d = data_bit ? shift_nxt : shreg_q;
      cnt_d   = (io_sync | complete) ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
   end

`ifdef NREG_DESER_PARITY_EN
   // running XOR of the data bits of the current frame
   always_comb begin
      par_d = (io_sync | complete) ? 1'b0 : data_bit ? par_q ^ io_bit_in : par_q;
   end
`endif

   // output buffer FSM: load on completion when empty or when the consumer takes the
   // old word on the same edge, otherwise a completion while full is an overrun
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
`ifdef NREG_DESER_PARITY_EN
      perr_d  = perr_q;
`endif
      case (state_q)
         EMPTY: begin
            if (complete) begin
               state_d = FULL;
               data_d  = word;
`ifdef NREG_DESER_PARITY_EN
               perr_d  = word_perr;
`endif
            end
         end
         FULL: begin
            if (complete && io_ready) begin
               data_d = word;
`ifdef NREG_DESER_PARITY_EN
               perr_d = word_perr;
`endif
            end else if (complete) begin
               ovr_d = 1'b1;
            end else if (io_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // state registers; reset discards both the partial word and any buffered word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         shreg_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef NREG_DESER_PARITY_EN
   // parity accumulator and the error flag delivered with each word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign io_parity_err = perr_q;
`endif

   assign io_D_out   = data_q;
   assign io_valid   = (state_q == FULL);
   assign io_overrun = ovr_q;
   assign io_bitcnt  = cnt_q;

endmodule

// File: tb/tb_nreg_sipo_deser.sv
// tb_nreg_sipo_deser: LSB-first and MSB-first instances on shared stimulus, checked every cycle against a queue-based model.
module tb_nreg_sipo_deser;

   localparam int W = 8;
`ifdef NREG_DESER_PARITY_EN
   localparam int FR = W + 1;
`else
   localparam int FR = W;
`endif
   localparam int CW = $clog2(FR);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic bit_in = 1'b0, bit_valid = 1'b0, sync = 1'b0, ready = 1'b0;
   logic [W-1:0] d0, d1;
   logic v0, v1, o0, o1;
   logic [CW-1:0] c0, c1;
`ifdef NREG_DESER_PARITY_EN
   logic pe0, pe1;
   bit epe;
`endif

   always #5 clk = ~clk;

   nreg_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset_n(reset_n), .io_bit_in(bit_in), .io_bit_valid(bit_valid),
      .io_sync(sync), .io_D_out(d0), .io_valid(v0), .io_ready(ready),
`ifdef NREG_DESER_PARITY_EN
      .io_parity_err(pe0),
`endif
      .io_overrun(o0), .io_bitcnt(c0));

   nreg_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset_n(reset_n), .io_bit_in(bit_in), .io_bit_valid(bit_valid),
      .io_sync(sync), .io_D_out(d1), .io_valid(v1), .io_ready(ready),
`ifdef NREG_DESER_PARITY_EN
      .io_parity_err(pe1),
`endif
      .io_overrun(o1), .io_bitcnt(c1));

   int checks = 0;
   int errors = 0;

   // model: the bits of the partial frame in arrival order plus the buffered word
   bit q[$];
   bit ev, eo;
   logic [W-1:0] e0, e1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit bv, input bit b, input bit s, input bit r);
      bit comp = 1'b0;
      logic [W-1:0] w0 = '0, w1 = '0;
      bit pe = 1'b0;
      if (s) q.delete();
      else if (bv) begin
         q.push_back(b);
         if (q.size() == FR) begin
            comp = 1'b1;
            for (int i = 0; i < W; i++) begin
               w0[i] = q[i];
               w1[W-1-i] = q[i];
            end
            for (int i = 0; i < FR; i++) pe ^= q[i];
            q.delete();
         end
      end
      if (comp && (!ev || r)) begin
         ev = 1'b1;
         e0 = w0;
         e1 = w1;
`ifdef NREG_DESER_PARITY_EN
         epe = pe;
`endif
      end else if (comp) eo = 1'b1;
      else if (ev && r) ev = 1'b0;
   endtask

   task automatic compare_all();
      chk("valid_lsb", v0, ev);
      chk("valid_msb", v1, ev);
      chk("overrun_lsb", o0, eo);
      chk("overrun_msb", o1, eo);
      chk("bitcnt_lsb", c0, q.size());
      chk("bitcnt_msb", c1, q.size());
      chk("data_lsb", d0, e0);
      chk("data_msb", d1, e1);
`ifdef NREG_DESER_PARITY_EN
      chk("perr_lsb", pe0, epe);
      chk("perr_msb", pe1, epe);
`endif
   endtask

   task automatic step(input bit bv, input bit b, input bit s, input bit r);
      bit_valid = bv;
      bit_in = b;
      sync = s;
      ready = r;
      @(posedge clk);
      #1;
      model_edge(bv, b, s, r);
      compare_all();
   endtask

   // frame of W data bits LSB first, then the parity bit when the feature is built
   task automatic send_word(input logic [W-1:0] w, input bit pbit, input bit r_mid, input bit r_last);
      for (int i = 0; i < FR; i++)
         step(1'b1, (i < W) ? w[i] : pbit, 1'b0, (i == FR - 1) ? r_last : r_mid);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      q.delete();
      ev = 1'b0;
      eo = 1'b0;
      e0 = '0;
      e1 = '0;
`ifdef NREG_DESER_PARITY_EN
      epe = 1'b0;
`endif
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("reset_data", d0, 8'h00);
      chk("reset_valid", v0, 1'b0);

      // bit stream 1,0,1,0,0,1,0,1 gives A5 in either bit order
      send_word(8'hA5, ^8'hA5, 1'b1, 1'b1);
      chk("t1_data_lsb", d0, 8'hA5);
      chk("t2_data_msb", d1, 8'hA5);
      chk("t1_valid", v0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t1_valid_one_cycle", v0, 1'b0);

      // overrun while the consumer stalls
      send_word(8'h3C, ^8'h3C, 1'b0, 1'b0);
      chk("t3_data_first", d0, 8'h3C);
      send_word(8'hFF, ^8'hFF, 1'b0, 1'b0);
      chk("t3_data_kept", d0, 8'h3C);
      chk("t3_valid", v0, 1'b1);
      chk("t3_overrun", o0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_consumed", v0, 1'b0);
      chk("t3_overrun_sticky", o0, 1'b1);

      // back-to-back load when ready arrives on the completing edge
      do_reset();
      send_word(8'h11, ^8'h11, 1'b0, 1'b0);
      chk("t4_first", d0, 8'h11);
      send_word(8'h22, ^8'h22, 1'b0, 1'b1);
      chk("t4_second", d0, 8'h22);
      chk("t4_valid", v0, 1'b1);
      chk("t4_no_overrun", o0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // sync discards a partial word
      do_reset();
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t5_partial", c0, 5);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t5_sync_cnt", c0, 0);
      send_word(8'h0F, ^8'h0F, 1'b0, 1'b0);
      chk("t5_data", d0, 8'h0F);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      chk("t5_reset_data", d0, 8'h00);
      chk("t5_reset_cnt", c0, 0);
      chk("t5_reset_valid", v0, 1'b0);

`ifdef NREG_DESER_PARITY_EN
      send_word(8'h07, 1'b1, 1'b1, 1'b1);
      chk("t6_parity_ok", pe0, 1'b0);
      send_word(8'h07, 1'b0, 1'b1, 1'b1);
      chk("t6_parity_bad", pe0, 1'b1);
      chk("t6_data", d0, 8'h07);
`endif

      // randomized traffic with varying consumer pressure and occasional sync/reset
      for (int n = 0; n < 3000; n++) begin
         int rbias;
         rbias = (n / 500) % 3;
         if ($urandom_range(0, 299) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 40) == 0, $urandom_range(0, rbias) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
